// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
//   Shared definitions for the iterative shift-add multiplier:
//     - mult_state_e       : FSM state encoding (IDLE, RUN, FIX, DONE)
//     - MULT_WIDTH_DEFAULT : default operand width
//     - MULT_CNT_W         : iteration counter width for the default width
//     - mult_cnt_width()   : counter width for an arbitrary operand width
// -----------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mult_state_e;

    localparam int MULT_WIDTH_DEFAULT = 32;
    localparam int MULT_CNT_W         = $clog2(MULT_WIDTH_DEFAULT);

    // A counter must still have at least one bit when the width is 1.
    function automatic int mult_cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage : mult_pkg

// File: rtl/mult_negate.sv
// -----------------------------------------------------------------------------
// mult_negate
//   Combinational conditional two's complement. It forms operand magnitudes
//   (N = WIDTH) and applies the result sign to the product (N = 2*WIDTH).
//
//   Ports:
//     neg_en  in  1 : 1 = output -din, 0 = output din unchanged
//     din     in  N : value to condition
//     dout    out N : din or its two's complement (mod 2^N)
// -----------------------------------------------------------------------------
module mult_negate #(
    parameter int N = 64
) (
    input  logic         neg_en,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);

    // -(-2^(N-1)) wraps back to 2^(N-1), which is exactly the unsigned
    // magnitude the datapath wants for the most negative operand.
    assign dout = neg_en ? (~din + N'(1)) : din;

endmodule : mult_negate

// File: rtl/mult_seq_engine.sv
// -----------------------------------------------------------------------------
// mult_seq_engine
//   Iterative radix-2 shift-add multiplier for MULT/MULTU. Each start forms
//   the 2*WIDTH-bit product in WIDTH RUN cycles plus one FIX cycle. The
//   result register feeds multiplyUnit.multResult.
//
//   Optional feature (macro MULT_MADD_EN): adds acc_en/acc_in so that FIX
//   returns product + acc_in (MADD/MADDU) at no extra latency.
//
//   Ports:
//     Clk         in   1        : clock, rising edge
//     Rst_n       in   1        : asynchronous active-low reset
//     start       in   1        : begin a multiply (only seen in IDLE/DONE)
//     is_signed   in   1        : 1 = MULT (two's complement), 0 = MULTU
//     a, b        in   WIDTH    : operands, sampled with start
//     flush       in   1        : synchronous abort, beats start everywhere
//     acc_en      in   1        : (MULT_MADD_EN) accumulate into acc_in
//     acc_in      in   2*WIDTH  : (MULT_MADD_EN) current HI:LO
//     busy        out  1        : high in RUN and FIX
//     done        out  1        : one-cycle pulse in DONE
//     multResult  out  2*WIDTH  : product, updated only on FIX->DONE
// -----------------------------------------------------------------------------
module mult_seq_engine
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               flush,
`ifdef MULT_MADD_EN
    input  logic               acc_en,
    input  logic [2*WIDTH-1:0] acc_in,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] multResult
);

    localparam int CNT_W = mult_cnt_width(WIDTH);
    localparam int PW    = 2 * WIDTH;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    mult_state_e        state_q,  state_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [WIDTH-1:0]   mcand_q,  mcand_d;   // |a|
    logic [PW-1:0]      prod_q,   prod_d;    // {partial product, multiplier}
    logic               neg_q,    neg_d;
    logic [PW-1:0]      result_q, result_d;
`ifdef MULT_MADD_EN
    logic               acc_en_q, acc_en_d;
    logic [PW-1:0]      acc_q,    acc_d;
`endif

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [PW-1:0]    prod_signed;
    logic [PW-1:0]    fix_value;
    logic [WIDTH:0]   upper_sum;
    logic [PW-1:0]    prod_step;
    logic             last_iter;

    mult_negate #(.N(WIDTH)) u_abs_a (
        .neg_en (is_signed & a[WIDTH-1]),
        .din    (a),
        .dout   (abs_a)
    );

    mult_negate #(.N(WIDTH)) u_abs_b (
        .neg_en (is_signed & b[WIDTH-1]),
        .din    (b),
        .dout   (abs_b)
    );

    mult_negate #(.N(PW)) u_fix_sign (
        .neg_en (neg_q),
        .din    (prod_q),
        .dout   (prod_signed)
    );

    // One shift-add step. The adder is one bit wider than the multiplicand
    // so the carry lands in the MSB after the right shift.
    always_comb begin
        upper_sum = {1'b0, prod_q[PW-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_step = {upper_sum, prod_q[WIDTH-1:1]};
    end

`ifdef MULT_MADD_EN
    assign fix_value = prod_signed + (acc_en_q ? acc_q : '0);
`else
    assign fix_value = prod_signed;
`endif

    assign last_iter = (count_q == CNT_W'(WIDTH - 1));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every *_d gets a default first so no path through the case
        // leaves a variable unassigned (which would infer a latch).
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        count_d  = count_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        result_d = result_q;
`ifdef MULT_MADD_EN
        acc_en_d = acc_en_q;
        acc_d    = acc_q;
`endif

        if (flush) begin
            // Abort: result register is left alone and no done pulse.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                        count_d = '0;
                        mcand_d = abs_a;
                        prod_d  = {{WIDTH{1'b0}}, abs_b};
                        neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULT_MADD_EN
                        acc_en_d = acc_en;
                        acc_d    = acc_in;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_RUN: begin
                    prod_d = prod_step;
                    if (last_iter) begin
                        state_d = ST_FIX;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end

                ST_FIX: begin
                    result_d = fix_value;
                    state_d  = ST_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end

                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, regardless of statement order.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
`ifdef MULT_MADD_EN
            acc_en_q <= 1'b0;
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            result_q <= result_d;
`ifdef MULT_MADD_EN
            acc_en_q <= acc_en_d;
            acc_q    <= acc_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign multResult = result_q;

endmodule : mult_seq_engine
